// File: rtl/mr_uart_pkg.sv
// Shared types and constants for the MazeRunner end of the Bluetooth UART command link.
package mr_uart_pkg;

  // Start bit, eight data bits and stop bit.
  localparam int UART_FRAME_BITS = 10;

  // Positive acknowledge returned to RemoteComm.
  localparam logic [7:0] POS_ACK = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

  typedef enum logic {
    ASM_WAIT_HI,
    ASM_WAIT_LO
  } asm_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter: loads {stop, data, start} into a shifter and clocks it out
// one bit per BAUD_DIV cycles. Requests made while a frame is in flight are dropped.
module uart_byte_tx
  import mr_uart_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_send,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam int FCW = $clog2(UART_FRAME_BITS);
  localparam logic [FCW-1:0] BIT_LAST = FCW'(UART_FRAME_BITS - 1);

  tx_state_t                  r_state;
  tx_state_t                  w_next;
  logic [UART_FRAME_BITS-1:0] r_shift;
  logic [FCW-1:0]             r_bit;
  logic [BCW-1:0]             r_baud;
  logic                       r_done;
  logic                       w_tick;

  assign w_tick = (r_baud == BAUD_LAST);

  // Next state: start on a request in IDLE, finish on the tick that ends the stop bit.
  always_comb begin
    // NOTE: assign every combinational output a default first so no path infers a latch.
    w_next = r_state;
    unique case (r_state)
      TX_IDLE: if (i_send) w_next = TX_BUSY;
      TX_BUSY: if (w_tick && (r_bit == BIT_LAST)) w_next = TX_IDLE;
      default: w_next = TX_IDLE;
    endcase
  end

  // State, shifter and counters; the shifter refills with ones so the line idles high.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    if (i_rst) begin
      r_state <= TX_IDLE;
      r_shift <= '1;
      r_bit   <= '0;
      r_baud  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == TX_BUSY) && (w_next == TX_IDLE);
      if (r_state == TX_IDLE) begin
        r_bit  <= '0;
        r_baud <= '0;
        if (i_send) r_shift <= {1'b1, i_data, 1'b0};
      end else begin
        r_baud <= w_tick ? '0 : r_baud + 1'b1;
        if (w_tick) begin
          r_shift <= {1'b1, r_shift[UART_FRAME_BITS-1:1]};
          r_bit   <= r_bit + 1'b1;
        end
      end
    end
  end

  assign o_tx   = r_shift[0];
  assign o_busy = (r_state == TX_BUSY);
  assign o_done = r_done;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// MazeRunner command link: receives two 8N1 bytes (high first) into a 16-bit command
// with an inter-byte timeout, and transmits a single response byte on request.
module uart_cmd_wrapper
  import mr_uart_pkg::*;
#(
  parameter int BAUD_DIV = 5208,
  parameter int GAP_TO   = 2 * UART_FRAME_BITS * BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err
);

  localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(BAUD_DIV / 2 - 1);
  localparam int GCW = (GAP_TO > 1) ? $clog2(GAP_TO) : 1;
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_TO - 1);

  // RX synchronizer and edge detect
  logic r_rx_meta;
  logic r_rx_sync;
  logic r_rx_prev;
  logic w_fall;
  logic w_start;

  // RX frame FSM
  rx_state_t  r_rx_state;
  rx_state_t  w_rx_next;
  logic [BCW-1:0] r_rx_baud;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_shift;
  logic       w_baud_tick;
  logic       w_rx_rdy;
  logic       w_stop_bad;
  logic       r_frm_err;

  // Command assembler
  asm_state_t r_asm_state;
  asm_state_t w_asm_next;
  logic [7:0]     r_hi;
  logic [GCW-1:0] r_gap_cnt;
  logic [15:0]    r_cmd;
  logic           r_cmd_rdy;
  logic           w_cmd_done;
  logic           w_hi_start;

  // Bring RX into the clk domain; flops preset high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall      = r_rx_prev & ~r_rx_sync;
  assign w_start     = (r_rx_state == RX_IDLE) && w_fall;
  assign w_baud_tick = (r_rx_baud == BAUD_LAST);

  // RX next state: glitch check at mid start bit, then one sample per bit period.
  always_comb begin
    w_rx_next  = r_rx_state;
    w_rx_rdy   = 1'b0;
    w_stop_bad = 1'b0;
    unique case (r_rx_state)
      RX_IDLE:  if (w_fall) w_rx_next = RX_START;
      RX_START: if (r_rx_baud == HALF_LAST) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_baud_tick && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP: begin
        if (w_baud_tick) begin
          w_rx_next  = RX_IDLE;
          w_rx_rdy   = r_rx_sync;
          w_stop_bad = ~r_rx_sync;
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  // RX state, bit timing and LSB-first data shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_frm_err  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_frm_err  <= w_stop_bad;
      unique case (r_rx_state)
        RX_IDLE: begin
          r_rx_baud <= '0;
          r_rx_bit  <= '0;
        end
        RX_START: r_rx_baud <= (r_rx_baud == HALF_LAST) ? '0 : r_rx_baud + 1'b1;
        default: begin
          r_rx_baud <= w_baud_tick ? '0 : r_rx_baud + 1'b1;
          if (w_baud_tick && (r_rx_state == RX_DATA)) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
          end
        end
      endcase
    end
  end

  assign w_cmd_done = (r_asm_state == ASM_WAIT_LO) && w_rx_rdy;
  assign w_hi_start = (r_asm_state == ASM_WAIT_HI) && w_start;

  // Assembler next state: a low byte, a framing error or a gap timeout all end WAIT_LO.
  always_comb begin
    w_asm_next = r_asm_state;
    unique case (r_asm_state)
      ASM_WAIT_HI: if (w_rx_rdy) w_asm_next = ASM_WAIT_LO;
      ASM_WAIT_LO: begin
        if (w_rx_rdy || w_stop_bad || (r_gap_cnt == GAP_LAST)) w_asm_next = ASM_WAIT_HI;
      end
      default: w_asm_next = ASM_WAIT_HI;
    endcase
  end

  // Assembler datapath: high-byte latch, gap timer, command register and ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm_state <= ASM_WAIT_HI;
      r_hi        <= '0;
      r_gap_cnt   <= '0;
      r_cmd       <= '0;
      r_cmd_rdy   <= 1'b0;
    end else begin
      r_asm_state <= w_asm_next;
      if (r_asm_state == ASM_WAIT_HI) begin
        r_gap_cnt <= '0;
        if (w_rx_rdy) r_hi <= r_rx_shift;
      end else begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end
      if (w_cmd_done) r_cmd <= {r_hi, r_rx_shift};
      // A completing command takes priority over an acknowledge in the same cycle.
      if (w_cmd_done)                     r_cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || w_hi_start) r_cmd_rdy <= 1'b0;
    end
  end

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;
  assign frm_err = r_frm_err;

  uart_byte_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_send (send_resp),
    .i_data (resp),
    .o_tx   (TX),
    .o_busy (tx_busy),
    .o_done (resp_sent)
  );

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper at BAUD_DIV=16: table of two-byte commands
// with optional leading disturbances, a command scoreboard, and hand-written TX,
// glitch and mid-frame reset sequences.
module tb_uart_cmd_wrapper;
  import mr_uart_pkg::*;

  localparam int BAUD = 16;
  localparam int GAP  = 2 * 10 * BAUD;

  logic        clk;
  logic        rst;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        tx_busy;
  logic        frm_err;

  uart_cmd_wrapper #(
    .BAUD_DIV (BAUD),
    .GAP_TO   (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .tx_busy     (tx_busy),
    .frm_err     (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_rdy_rises = 0;
  int n_frm_cycles = 0;
  int rises0;
  int frm0;
  logic [15:0] exp_q[$];

  typedef enum {PRE_NONE, PRE_TIMEOUT, PRE_BADSTOP} pre_t;
  typedef struct {
    pre_t        pre;
    logic [7:0]  pre_byte;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp_cmd;
    int          exp_frm;
  } cmd_vec_t;

  cmd_vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One 8N1 frame, each bit held BAUD cycles, line left idle high afterwards.
  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      RX = frame[i];
      repeat (BAUD - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    RX = 1'b1;
  endtask

  task automatic clr_pulse(input logic [15:0] exp_cmd);
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
    #1;
    check("clr_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("cmd_hold", 32'(cmd), 32'(exp_cmd));
  endtask

  // Sends r and checks the line mid-bit against the expected frame; optionally
  // fires a second request mid-frame that must be ignored.
  task automatic tx_check(input logic [7:0] r, input bit inject);
    logic [9:0] frame;
    frame = {1'b1, r, 1'b0};
    @(posedge clk); #1;
    resp      = r;
    send_resp = 1'b1;
    @(posedge clk); #1;
    send_resp = 1'b0;
    for (int c = 0; c <= 161; c++) begin
      if (inject && c == 50) begin
        resp      = ~r;
        send_resp = 1'b1;
      end else begin
        send_resp = 1'b0;
      end
      #1;
      if (c < 160 && (c % 16) == 8) check("tx_bit", 32'(TX), 32'(frame[c/16]));
      if (c == 0 || c == 159) check("tx_busy_on", 32'(tx_busy), 32'd1);
      if (c == 159) check("resp_sent_early", 32'(resp_sent), 32'd0);
      if (c == 160) begin
        check("tx_busy_off", 32'(tx_busy), 32'd0);
        check("resp_sent", 32'(resp_sent), 32'd1);
        check("tx_idle_high", 32'(TX), 32'd1);
      end
      if (c == 161) check("resp_sent_width", 32'(resp_sent), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard and pulse counters, sampled on the falling edge.
  initial begin
    logic prev_rdy;
    logic [15:0] exp;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_rdy && !prev_rdy) begin
        n_rdy_rises++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: cmd_rdy rose with cmd=0x%h, no command expected", cmd);
        end else begin
          exp = exp_q.pop_front();
          check("sb_cmd", 32'(cmd), 32'(exp));
        end
      end
      prev_rdy = cmd_rdy;
      if (frm_err) n_frm_cycles++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{PRE_NONE,    8'h00, 8'h12, 8'h34, 16'h1234, 0};
    vecs[1] = '{PRE_TIMEOUT, 8'h23, 8'hFF, 8'h00, 16'hFF00, 0};
    vecs[2] = '{PRE_BADSTOP, 8'h60, 8'h60, 8'h01, 16'h6001, 1};
    vecs[3] = '{PRE_NONE,    8'h00, 8'h00, 8'hFF, 16'h00FF, 0};
    vecs[4] = '{PRE_NONE,    8'h00, 8'hA5, 8'h5A, 16'hA55A, 0};

    rst         = 1'b1;
    RX          = 1'b1;
    clr_cmd_rdy = 1'b0;
    resp        = 8'h00;
    send_resp   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_resp_sent", 32'(resp_sent), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_frm_err", 32'(frm_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // 0x40, 0x02: cmd_rdy rises exactly one clock after the low byte's stop-bit sample
    exp_q.push_back(16'h4002);
    uart_send(8'h40, 1'b1);
    fork
      uart_send(8'h02, 1'b1);
      begin
        repeat (155) @(posedge clk);
        #2;
        check("t1_rdy_before", 32'(cmd_rdy), 32'd0);
        @(posedge clk); #2;
        check("t1_rdy_at", 32'(cmd_rdy), 32'd1);
        check("t1_cmd", 32'(cmd), 32'h4002);
      end
    join
    clr_pulse(16'h4002);

    // Command table, including timeout and bad-stop disturbances ahead of the command
    for (int i = 0; i < 5; i++) begin
      rises0 = n_rdy_rises;
      frm0   = n_frm_cycles;
      case (vecs[i].pre)
        PRE_TIMEOUT: begin
          uart_send(vecs[i].pre_byte, 1'b1);
          repeat (GAP + 10) @(posedge clk);
        end
        PRE_BADSTOP: begin
          uart_send(vecs[i].pre_byte, 1'b0);
          repeat (BAUD) @(posedge clk);
        end
        default: ;
      endcase
      exp_q.push_back(vecs[i].exp_cmd);
      uart_send(vecs[i].hi, 1'b1);
      uart_send(vecs[i].lo, 1'b1);
      repeat (2) @(posedge clk);
      #2;
      check("vec_cmd", 32'(cmd), 32'(vecs[i].exp_cmd));
      check("vec_cmd_rdy", 32'(cmd_rdy), 32'd1);
      check("vec_rdy_rises", 32'(n_rdy_rises - rises0), 32'd1);
      check("vec_frm_err", 32'(n_frm_cycles - frm0), 32'(vecs[i].exp_frm));
      clr_pulse(vecs[i].exp_cmd);
    end

    // Positive acknowledge with a second request mid-frame that must be dropped
    tx_check(POS_ACK, 1'b1);

    // 4-clock low glitch: no frame, no framing error, assembler still waiting for a high byte
    rises0 = n_rdy_rises;
    frm0   = n_frm_cycles;
    @(posedge clk); #1;
    RX = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    RX = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    check("glitch_frm_err", 32'(n_frm_cycles - frm0), 32'd0);
    check("glitch_rdy", 32'(n_rdy_rises - rises0), 32'd0);
    check("glitch_cmd", 32'(cmd), 32'hA55A);
    exp_q.push_back(16'h1357);
    uart_send(8'h13, 1'b1);
    uart_send(8'h57, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    check("post_glitch_cmd", 32'(cmd), 32'h1357);
    check("post_glitch_rdy", 32'(cmd_rdy), 32'd1);

    // Reset mid low byte and mid response; cmd_rdy left set so the new start bit clears it
    rises0 = n_rdy_rises;
    fork
      begin
        uart_send(8'h77, 1'b1);
        uart_send(8'hF0, 1'b1);
      end
      begin
        repeat (10) @(posedge clk);
        #2;
        check("start_clears_rdy", 32'(cmd_rdy), 32'd0);
        repeat (170) @(posedge clk);
        #1;
        resp      = POS_ACK;
        send_resp = 1'b1;
        @(posedge clk); #1;
        send_resp = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #2;
        check("rst_mid_tx", 32'(TX), 32'd1);
        check("rst_mid_busy", 32'(tx_busy), 32'd0);
        check("rst_mid_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_mid_cmd", 32'(cmd), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    #2;
    check("aborted_no_cmd", 32'(n_rdy_rises - rises0), 32'd0);

    exp_q.push_back(16'h0000);
    uart_send(8'h00, 1'b1);
    uart_send(8'h00, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    check("post_rst_rdy", 32'(cmd_rdy), 32'd1);
    check("post_rst_rises", 32'(n_rdy_rises - rises0), 32'd1);
    clr_pulse(16'h0000);
    tx_check(POS_ACK, 1'b0);

    repeat (5) @(posedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
